// File: rtl/insn_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | insn_issue: instruction FIFO + 4-entry regfile + EX pipeline register |
// | feeding an external ALU, with writeback and EX->IS operand bypass.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module insn_issue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_insn,
  input  logic             run,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_rs,
  output logic [WIDTH-1:0] alu_rt,
  input  logic [WIDTH-1:0] alu_rd,
  output logic             wb_valid,
  output logic [1:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic [1:0]       obs_addr,
  output logic [WIDTH-1:0] obs_data,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [AW:0]   c_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   c_CNT_FULL = (AW + 1)'(DEPTH);

  logic [8:0]       fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rf_q [4];

  logic             ex_valid_q;
  logic [1:0]       ex_dst_q;
  logic [2:0]       alu_sel_q;
  logic [WIDTH-1:0] alu_rs_q, alu_rt_q;

  logic             push, pop, empty;
  logic [8:0]       head;
  logic [1:0]       src1, src2;
  logic [WIDTH-1:0] rs_d, rt_d;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != c_CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = run && !empty;

  assign head = fifo_q[rd_ptr_q];
  assign src1 = head[3:2];
  assign src2 = head[1:0];

  // The instruction in EX writes its result at the same edge this one issues,
  // so a matching source must take the ALU result directly.
  assign rs_d = (ex_valid_q && (src1 == ex_dst_q)) ? alu_rd : rf_q[src1];
  assign rt_d = (ex_valid_q && (src2 == ex_dst_q)) ? alu_rd : rf_q[src2];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_insn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_dst_q   <= '0;
      alu_sel_q  <= '0;
      alu_rs_q   <= '0;
      alu_rt_q   <= '0;
    end else begin
      ex_valid_q <= pop;
      if (pop) begin
        ex_dst_q  <= head[5:4];
        alu_sel_q <= head[8:6];
        alu_rs_q  <= rs_d;
        alu_rt_q  <= rt_d;
      end
    end
  end

  // Host loads only land while idle, so they never collide with writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (ex_valid_q) begin
      rf_q[ex_dst_q] <= alu_rd;
    end else if (ld_en && !busy) begin
      rf_q[ld_addr] <= ld_data;
    end
  end

  assign busy     = !empty || ex_valid_q;
  assign alu_sel  = alu_sel_q;
  assign alu_rs   = alu_rs_q;
  assign alu_rt   = alu_rt_q;
  assign wb_valid = ex_valid_q;
  assign wb_addr  = ex_dst_q;
  assign wb_data  = alu_rd;
  assign obs_data = rf_q[obs_addr];

endmodule
`default_nettype wire
